// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_sched_pkg : shared types/constants for the FIFO port scheduler   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_t;

  localparam logic CONFLICT_WRITE = 1'b0;
  localparam logic CONFLICT_READ  = 1'b1;

endpackage : fifo_sched_pkg
`default_nettype wire

// File: rtl/fifo_port_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational rotate-priority arbiter, search starts     |
// | one past i_last and wraps.                     Rev 1.0                |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((32'(i_last) + 32'(k)) % 32'(N));
      if (!o_any && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_port_scheduler : shares a one-op-per-cycle sync FIFO between     |
// | N_REQ round-robin writers and one reader.      Rev 1.0                |
// +----------------------------------------------------------------------+
module fifo_port_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic                   i_rd_req,
  output logic                   o_rd_accept,
  output logic                   o_rd_valid,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_fifo_write,
  output logic                   o_fifo_read,
  output logic                   o_fifo_clear,
  output logic [WIDTH-1:0]       o_fifo_data_in,
  input  logic [WIDTH-1:0]       i_fifo_data_out,
  input  logic                   i_fifo_full,
  input  logic                   i_fifo_empty
);

  localparam int IDX_W = $clog2(N_REQ);

  generate
    if (N_REQ < 2 || WIDTH < 1 || DEPTH < 1) begin : g_param_check
      $error("fifo_port_scheduler: illegal parameter set");
    end
  endgenerate

  logic [IDX_W-1:0] r_rr_last;
  logic             r_conflict_pref;
  logic             r_rd_valid;

  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_wr_cand;
  logic             w_rd_cand;
  logic             w_conflict;
  op_t              w_op;
  logic [WIDTH-1:0] w_wdata;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_req  (i_req_valid),
    .i_last (r_rr_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_wr_cand = w_any && !i_fifo_full;
  assign w_rd_cand = i_rd_req && !i_fifo_empty;

  // Reset is folded in so strobes drop the instant reset rises, not at the next edge.
  always_comb begin
    w_op       = OP_NONE;
    w_conflict = 1'b0;
    if (!reset && !i_clear) begin
      if (w_wr_cand && w_rd_cand) begin
        w_conflict = 1'b1;
        w_op       = (r_conflict_pref == CONFLICT_WRITE) ? OP_WRITE : OP_READ;
      end else if (w_wr_cand) begin
        w_op = OP_WRITE;
      end else if (w_rd_cand) begin
        w_op = OP_READ;
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_wdata = w_wdata | i_req_data[i*WIDTH +: WIDTH];
    end
  end

  assign o_req_ready    = (w_op == OP_WRITE) ? w_gnt : '0;
  assign o_fifo_write   = (w_op == OP_WRITE);
  assign o_fifo_read    = (w_op == OP_READ);
  assign o_rd_accept    = (w_op == OP_READ);
  assign o_fifo_clear   = i_clear && !reset;
  assign o_fifo_data_in = (w_op == OP_WRITE) ? w_wdata : '0;
  assign o_rd_data      = i_fifo_data_out;
  // A read landing just before a flush carries pre-flush data, so it is suppressed.
  assign o_rd_valid     = r_rd_valid && !i_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last       <= IDX_W'(N_REQ - 1);
      r_conflict_pref <= CONFLICT_WRITE;
      r_rd_valid      <= 1'b0;
    end else if (i_clear) begin
      r_rr_last       <= IDX_W'(N_REQ - 1);
      r_conflict_pref <= CONFLICT_WRITE;
      r_rd_valid      <= 1'b0;
    end else begin
      if (w_op == OP_WRITE) r_rr_last <= w_idx;
      if (w_conflict) r_conflict_pref <= ~r_conflict_pref;
      r_rd_valid <= (w_op == OP_READ);
    end
  end

endmodule : fifo_port_scheduler
`default_nettype wire
